// File: rtl/data_memory_controller_pkg.sv
// Shared encodings for the data-memory command bus, so decode and the
// memory controller agree on field positions and size/funct3 codes.
package data_memory_controller_pkg;

    // MEM_WRITE = {enable, size}; MEM_READ = {enable, funct3}
    localparam int WR_EN_BIT = 2;
    localparam int RD_EN_BIT = 3;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam logic [2:0] LOAD_LB  = 3'b000;
    localparam logic [2:0] LOAD_LH  = 3'b001;
    localparam logic [2:0] LOAD_LW  = 3'b010;
    localparam logic [2:0] LOAD_LBU = 3'b100;
    localparam logic [2:0] LOAD_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    // Illegal encoding or misaligned address for the given access
    function automatic logic is_fault(input logic       store,
                                      input logic [1:0] size,
                                      input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
        logic f;
        f = 1'b1;
        if (store) begin
            case (size)
                SIZE_B:  f = 1'b0;
                SIZE_H:  f = addr_lo[0];
                SIZE_W:  f = |addr_lo;
                default: f = 1'b1;
            endcase
        end else begin
            case (funct3)
                LOAD_LB, LOAD_LBU: f = 1'b0;
                LOAD_LH, LOAD_LHU: f = addr_lo[0];
                LOAD_LW:           f = |addr_lo;
                default:           f = 1'b1;
            endcase
        end
        return f;
    endfunction

endpackage

// File: rtl/data_memory_controller_load_store_align.sv
// Byte-lane steering between a 32-bit memory word and the register file:
// load lane select with sign/zero extension, store lane replication with
// byte enables. Purely combinational so a cache can reuse it.
module load_store_align
    import data_memory_controller_pkg::*;
(
    input  logic [31:0] rword,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic [3:0]  be,
    output logic [31:0] st_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Load path: pick the addressed lane, then extend
    always_comb begin
        byte_sel = rword[7:0];
        case (addr_lo)
            2'd0:    byte_sel = rword[7:0];
            2'd1:    byte_sel = rword[15:8];
            2'd2:    byte_sel = rword[23:16];
            default: byte_sel = rword[31:24];
        endcase
        half_sel = addr_lo[1] ? rword[31:16] : rword[15:0];
        case (funct3)
            LOAD_LB:  ld_data = {{24{byte_sel[7]}}, byte_sel};
            LOAD_LH:  ld_data = {{16{half_sel[15]}}, half_sel};
            LOAD_LBU: ld_data = {24'd0, byte_sel};
            LOAD_LHU: ld_data = {16'd0, half_sel};
            default:  ld_data = rword;
        endcase
    end

    // Store path: replicate the low lanes across the word, enable only the target lanes
    always_comb begin
        be      = 4'b0000;
        st_data = wdata;
        case (size)
            SIZE_B: begin
                st_data = {4{wdata[7:0]}};
                be      = 4'b0001 << addr_lo;
            end
            SIZE_H: begin
                st_data = {2{wdata[15:0]}};
                be      = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            SIZE_W: begin
                st_data = wdata;
                be      = 4'b1111;
            end
            default: begin
                st_data = wdata;
                be      = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_controller.sv
// Data-memory responder: latches a load/store command from decode, models
// main memory with a fixed access latency, and stalls the pipeline via BUSY.
module data_memory_controller
    import data_memory_controller_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [2:0]  MEM_WRITE,
    input  logic [3:0]  MEM_READ,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    output logic [31:0] READ_DATA,
    output logic        BUSY,
    output logic        ACCESS_FAULT
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

    mem_state_t        state;
    logic [3:0]        cnt;
    logic              st_q;
    logic [1:0]        size_q;
    logic [2:0]        f3_q;
    logic [IDX_W+1:0]  addr_q;
    logic [31:0]       wdata_q;

    logic [31:0] mem [DEPTH];
    logic [31:0] rword, ld_data, st_data;
    logic [3:0]  be;
    logic        req, store_req, fault_now, mem_we;
    logic        unused_addr;

    // Upper address bits wrap away
    assign unused_addr = ^ADDRESS[31:IDX_W+2];

    // A simultaneous store and load executes the store only
    assign store_req = MEM_WRITE[WR_EN_BIT];
    assign req       = store_req | MEM_READ[RD_EN_BIT];
    assign fault_now = is_fault(store_req, MEM_WRITE[1:0], MEM_READ[2:0], ADDRESS[1:0]);
    assign rword     = mem[addr_q[IDX_W+1:2]];
    assign mem_we    = RESET && (state == ST_WAIT) && (cnt == 4'd0) && st_q;

    load_store_align u_align (
        .rword   (rword),
        .addr_lo (addr_q[1:0]),
        .funct3  (f3_q),
        .size    (size_q),
        .wdata   (wdata_q),
        .ld_data (ld_data),
        .be      (be),
        .st_data (st_data)
    );

    // Stall: raised in IDLE as soon as decode asserts a request, held through WAIT
    always_comb begin
        BUSY = 1'b0;
        if (RESET) begin
            case (state)
                ST_IDLE: BUSY = req;
                ST_WAIT: BUSY = 1'b1;
                default: BUSY = 1'b0;
            endcase
        end
    end

    // Access FSM: latch in IDLE, count down in WAIT, retire in DONE
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state        <= ST_IDLE;
            cnt          <= 4'd0;
            READ_DATA    <= 32'd0;
            ACCESS_FAULT <= 1'b0;
            st_q         <= 1'b0;
            size_q       <= 2'd0;
            f3_q         <= 3'd0;
            addr_q       <= '0;
            wdata_q      <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ACCESS_FAULT <= 1'b0;
                    if (req) begin
                        st_q    <= store_req;
                        size_q  <= MEM_WRITE[1:0];
                        f3_q    <= MEM_READ[2:0];
                        addr_q  <= ADDRESS[IDX_W+1:0];
                        wdata_q <= WRITE_DATA;
                        if (fault_now) begin
                            state        <= ST_DONE;
                            ACCESS_FAULT <= 1'b1;
                            if (!store_req) READ_DATA <= 32'd0;
                        end else begin
                            state <= ST_WAIT;
                            cnt   <= LAT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        if (!st_q) READ_DATA <= ld_data;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    // Request still visible here belongs to the retiring instruction
                    ACCESS_FAULT <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Memory array: lane-masked commit, contents survive reset
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[addr_q[IDX_W+1:2]][8*b +: 8] <= st_data[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_data_memory_controller.sv
// Directed bench for data_memory_controller (DEPTH=256, LATENCY=3).
module tb_data_memory_controller;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [2:0]  MEM_WRITE = 3'd0;
    logic [3:0]  MEM_READ = 4'd0;
    logic [31:0] ADDRESS = 32'd0;
    logic [31:0] WRITE_DATA = 32'd0;
    logic [31:0] READ_DATA;
    logic        BUSY;
    logic        ACCESS_FAULT;

    int checks = 0;
    int errors = 0;

    // Command encodings as decode would drive them
    localparam logic [2:0] W_SB = 3'b100, W_SH = 3'b101, W_SW = 3'b110, W_NONE = 3'b000;
    localparam logic [3:0] R_LB = 4'b1000, R_LH = 4'b1001, R_LW = 4'b1010,
                           R_LBU = 4'b1100, R_LHU = 4'b1101, R_BAD = 4'b1011, R_NONE = 4'b0000;

    data_memory_controller #(.DEPTH(256), .LATENCY(3)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .MEM_WRITE    (MEM_WRITE),
        .MEM_READ     (MEM_READ),
        .ADDRESS      (ADDRESS),
        .WRITE_DATA   (WRITE_DATA),
        .READ_DATA    (READ_DATA),
        .BUSY         (BUSY),
        .ACCESS_FAULT (ACCESS_FAULT)
    );

    always #5 CLK = ~CLK;

    // Issue one instruction, count BUSY cycles, sample the DONE cycle,
    // keep the request up through the retiring edge, then report BUSY after it.
    task automatic run_access(input logic [2:0] wr, input logic [3:0] rd,
                              input logic [31:0] addr, input logic [31:0] wd,
                              output int nbusy, output logic [31:0] rdata,
                              output logic fault, output logic post_busy);
        nbusy = 0;
        @(negedge CLK);
        MEM_WRITE = wr; MEM_READ = rd; ADDRESS = addr; WRITE_DATA = wd;
        #1;
        while (BUSY && nbusy < 40) begin
            nbusy++;
            @(negedge CLK);
            if (nbusy == 1) begin
                ADDRESS = $urandom;
                WRITE_DATA = $urandom;
            end
            #1;
        end
        rdata = READ_DATA;
        fault = ACCESS_FAULT;
        @(posedge CLK);
        #1;
        MEM_WRITE = W_NONE; MEM_READ = R_NONE;
        #1;
        post_busy = BUSY;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        MEM_WRITE = W_SW; ADDRESS = 32'h10; WRITE_DATA = 32'h1;
        @(negedge CLK); #1;
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", BUSY); end
        checks++; if (READ_DATA !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h exp 0", READ_DATA); end
        checks++; if (ACCESS_FAULT !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", ACCESS_FAULT); end
        MEM_WRITE = W_NONE;
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK); #1;
            checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL idle_busy cyc %0d got %b exp 0", i, BUSY); end
        end
    endtask

    task automatic test_word();
        int n; logic [31:0] rdv; logic f, pb;
        run_access(W_SW, R_NONE, 32'h10, 32'hDEADBEEF, n, rdv, f, pb);
        checks++; if (n !== 4) begin errors++; $display("FAIL sw_busy got %0d exp 4", n); end
        checks++; if (f !== 1'b0) begin errors++; $display("FAIL sw_fault got %b exp 0", f); end
        checks++; if (pb !== 1'b0) begin errors++; $display("FAIL sw_restart busy got %b exp 0", pb); end
        run_access(W_NONE, R_LW, 32'h10, 32'h0, n, rdv, f, pb);
        checks++; if (n !== 4) begin errors++; $display("FAIL lw_busy got %0d exp 4", n); end
        checks++; if (rdv !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got %h exp deadbeef", rdv); end
        checks++; if (f !== 1'b0) begin errors++; $display("FAIL lw_fault got %b exp 0", f); end
        checks++; if (pb !== 1'b0) begin errors++; $display("FAIL lw_restart busy got %b exp 0", pb); end
    endtask

    task automatic test_byte();
        int n; logic [31:0] rdv; logic f, pb;
        run_access(W_SB, R_NONE, 32'h11, 32'hAAAAAA7F, n, rdv, f, pb);
        checks++; if (n !== 4) begin errors++; $display("FAIL sb_busy got %0d exp 4", n); end
        run_access(W_NONE, R_LB, 32'h11, 32'h0, n, rdv, f, pb);
        checks++; if (rdv !== 32'h0000007F) begin errors++; $display("FAIL lb_11 got %h exp 0000007f", rdv); end
        run_access(W_NONE, R_LBU, 32'h13, 32'h0, n, rdv, f, pb);
        checks++; if (rdv !== 32'h000000DE) begin errors++; $display("FAIL lbu_13 got %h exp 000000de", rdv); end
        run_access(W_NONE, R_LB, 32'h10, 32'h0, n, rdv, f, pb);
        checks++; if (rdv !== 32'hFFFFFFEF) begin errors++; $display("FAIL lb_10 got %h exp ffffffef", rdv); end
        run_access(W_NONE, R_LW, 32'h10, 32'h0, n, rdv, f, pb);
        checks++; if (rdv !== 32'hDEAD7FEF) begin errors++; $display("FAIL lw_after_sb got %h exp dead7fef", rdv); end
    endtask

    task automatic test_half();
        int n; logic [31:0] rdv; logic f, pb;
        run_access(W_SH, R_NONE, 32'h12, 32'h55558001, n, rdv, f, pb);
        checks++; if (f !== 1'b0) begin errors++; $display("FAIL sh_fault got %b exp 0", f); end
        run_access(W_NONE, R_LH, 32'h12, 32'h0, n, rdv, f, pb);
        checks++; if (rdv !== 32'hFFFF8001) begin errors++; $display("FAIL lh_12 got %h exp ffff8001", rdv); end
        run_access(W_NONE, R_LHU, 32'h12, 32'h0, n, rdv, f, pb);
        checks++; if (rdv !== 32'h00008001) begin errors++; $display("FAIL lhu_12 got %h exp 00008001", rdv); end
        run_access(W_NONE, R_LH, 32'h10, 32'h0, n, rdv, f, pb);
        checks++; if (rdv !== 32'h00007FEF) begin errors++; $display("FAIL lh_10 got %h exp 00007fef", rdv); end
    endtask

    task automatic test_fault();
        int n; logic [31:0] rdv; logic f, pb;
        run_access(W_NONE, R_LW, 32'h12, 32'h0, n, rdv, f, pb);
        checks++; if (n !== 1) begin errors++; $display("FAIL lw_mis_busy got %0d exp 1", n); end
        checks++; if (f !== 1'b1) begin errors++; $display("FAIL lw_mis_fault got %b exp 1", f); end
        checks++; if (rdv !== 32'd0) begin errors++; $display("FAIL lw_mis_data got %h exp 0", rdv); end
        checks++; if (ACCESS_FAULT !== 1'b0) begin errors++; $display("FAIL fault_pulse got %b exp 0", ACCESS_FAULT); end
        run_access(W_SH, R_NONE, 32'h13, 32'h0000FFFF, n, rdv, f, pb);
        checks++; if (n !== 1) begin errors++; $display("FAIL sh_mis_busy got %0d exp 1", n); end
        checks++; if (f !== 1'b1) begin errors++; $display("FAIL sh_mis_fault got %b exp 1", f); end
        run_access(W_NONE, R_LW, 32'h10, 32'h0, n, rdv, f, pb);
        checks++; if (rdv !== 32'h80017FEF) begin errors++; $display("FAIL unchanged got %h exp 80017fef", rdv); end
        run_access(W_NONE, R_BAD, 32'h10, 32'h0, n, rdv, f, pb);
        checks++; if (n !== 1) begin errors++; $display("FAIL f3_bad_busy got %0d exp 1", n); end
        checks++; if (f !== 1'b1) begin errors++; $display("FAIL f3_bad_fault got %b exp 1", f); end
        checks++; if (rdv !== 32'd0) begin errors++; $display("FAIL f3_bad_data got %h exp 0", rdv); end
    endtask

    task automatic test_store_wins();
        int n; logic [31:0] rdv; logic f, pb;
        run_access(W_NONE, R_LW, 32'h10, 32'h0, n, rdv, f, pb);
        run_access(W_SW, R_LW, 32'h30, 32'h0BADF00D, n, rdv, f, pb);
        checks++; if (n !== 4) begin errors++; $display("FAIL both_busy got %0d exp 4", n); end
        checks++; if (rdv !== 32'h80017FEF) begin errors++; $display("FAIL both_rdata got %h exp 80017fef", rdv); end
        run_access(W_NONE, R_LW, 32'h30, 32'h0, n, rdv, f, pb);
        checks++; if (rdv !== 32'h0BADF00D) begin errors++; $display("FAIL both_store got %h exp 0badf00d", rdv); end
    endtask

    task automatic test_reset_abort();
        int n; logic [31:0] rdv; logic f, pb;
        run_access(W_SW, R_NONE, 32'h20, 32'h11112222, n, rdv, f, pb);
        run_access(W_NONE, R_LW, 32'h20, 32'h0, n, rdv, f, pb);
        @(negedge CLK);
        MEM_WRITE = W_SW; ADDRESS = 32'h20; WRITE_DATA = 32'h12345678;
        @(negedge CLK);
        @(negedge CLK); #1;
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL abort_pre_busy got %b exp 1", BUSY); end
        RESET = 1'b0; #1;
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", BUSY); end
        checks++; if (READ_DATA !== 32'd0) begin errors++; $display("FAIL abort_rdata got %h exp 0", READ_DATA); end
        @(negedge CLK);
        MEM_WRITE = W_NONE;
        @(negedge CLK);
        RESET = 1'b1; #1;
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL abort_idle got %b exp 0", BUSY); end
        run_access(W_NONE, R_LW, 32'h20, 32'h0, n, rdv, f, pb);
        checks++; if (n !== 4) begin errors++; $display("FAIL abort_lw_busy got %0d exp 4", n); end
        checks++; if (rdv !== 32'h11112222) begin errors++; $display("FAIL abort_lw got %h exp 11112222", rdv); end
    endtask

    task automatic test_back_to_back();
        int n; logic [31:0] rdv; logic f, pb;
        run_access(W_SW, R_NONE, 32'h410, 32'hCAFEF00D, n, rdv, f, pb);
        run_access(W_NONE, R_LW, 32'h10, 32'h0, n, rdv, f, pb);
        checks++; if (n !== 4) begin errors++; $display("FAIL b2b_first_busy got %0d exp 4", n); end
        checks++; if (rdv !== 32'hCAFEF00D) begin errors++; $display("FAIL wrap got %h exp cafef00d", rdv); end
        run_access(W_NONE, R_LW, 32'h30, 32'h0, n, rdv, f, pb);
        checks++; if (n !== 4) begin errors++; $display("FAIL b2b_second_busy got %0d exp 4", n); end
        checks++; if (rdv !== 32'h0BADF00D) begin errors++; $display("FAIL b2b_second got %h exp 0badf00d", rdv); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_word();
        test_byte();
        test_half();
        test_fault();
        test_store_wins();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
